tape_demod: RTL and testbench

TAPE_DEMOD -- requirements
Module: tape_demod

---
 rtl/tape_pkg.sv | 22 ++
 rtl/tape_debounce.sv | 35 +++
 rtl/tape_demod.sv | 190 +++++++++++++++++++
 tb/tb_tape_demod.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/tape_pkg.sv
// Shared encodings and default timing constants for the cassette FSK demodulator.
package tape_pkg;

  typedef enum logic [1:0] {
    ST_HUNT       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_DATA       = 2'd2,
    ST_STOP       = 2'd3
  } frame_state_t;

  typedef enum logic {
    HALF_S = 1'b0,
    HALF_L = 1'b1
  } half_t;

  localparam int CNT_W           = 16;
  localparam int DEF_SHORT_MAX   = 5000;
  localparam int DEF_TIMEOUT     = 10000;
  localparam int DEF_LEADER_BITS = 16;
  localparam int DEF_GLITCH_CLKS = 64;

endpackage

// File: rtl/tape_debounce.sv
// Glitch filter: the output follows din only after din has differed from it for
// GLITCH_CLKS consecutive cycles. Built only when TAPE_DEMOD_GLITCH_EN is defined.
module tape_debounce
  import tape_pkg::*;
#(
  parameter int GLITCH_CLKS = DEF_GLITCH_CLKS
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int GW = $clog2(GLITCH_CLKS + 1);

  logic          r_out;
  logic [GW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= 1'b0;
      r_cnt <= '0;
    end else if (din == r_out) begin
      r_cnt <= '0;
    end else if (r_cnt == GW'(GLITCH_CLKS - 1)) begin
      r_out <= din;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign dout = r_out;

endmodule

// File: rtl/tape_demod.sv
// 1200 baud Acorn cassette FSK demodulator: edge-interval half classification,
// bit assembly and byte framing. Optional glitch filter under TAPE_DEMOD_GLITCH_EN.
module tape_demod
  import tape_pkg::*;
#(
  parameter int SHORT_MAX   = DEF_SHORT_MAX,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int LEADER_BITS = DEF_LEADER_BITS,
  parameter int GLITCH_CLKS = DEF_GLITCH_CLKS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tape_in,
  output logic [7:0] dout,
  output logic       data_valid,
  output logic       frame_err,
  output logic       carrier
);

  localparam int                LEAD_W  = $clog2(LEADER_BITS + 1);
  localparam logic [CNT_W-1:0]  C_SHORT = CNT_W'(SHORT_MAX);
  localparam logic [CNT_W-1:0]  C_TO    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  C_TO_M1 = CNT_W'(TIMEOUT - 1);

  if (SHORT_MAX >= TIMEOUT || TIMEOUT > 65535 || LEADER_BITS < 1 || GLITCH_CLKS < 1)
  begin : g_bad_params
    $error("tape_demod: inconsistent timing parameters");
  end

  logic             r_sync1, r_sync2, r_lvl_prev, r_first;
  logic [CNT_W-1:0] r_cnt;
  logic             w_lvl, w_edge, w_timeout;
  logic             w_half_vld;
  half_t            w_half;
  logic             w_bit_vld, w_bit;
  logic [1:0]       w_pend_s_nx;
  logic             w_pend_l_nx;

  frame_state_t     r_state;
  logic [LEAD_W-1:0] r_lead;
  logic [2:0]       r_idx;
  logic [1:0]       r_pend_s;
  logic             r_pend_l;
  logic [7:0]       r_shift, r_dout;
  logic             r_dv, r_fe, r_carrier;

`ifdef TAPE_DEMOD_GLITCH_EN
  tape_debounce #(.GLITCH_CLKS(GLITCH_CLKS)) u_debounce (
    .clk   (clk),
    .reset (reset),
    .din   (r_sync2),
    .dout  (w_lvl)
  );
`else
  assign w_lvl = r_sync2;
`endif

  assign w_edge    = (w_lvl != r_lvl_prev);
  assign w_timeout = !w_edge && (r_cnt == C_TO_M1);

  // Synchronizer, edge detect and saturating interval counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_lvl_prev <= 1'b0;
      r_cnt      <= '0;
      r_first    <= 1'b1;
    end else begin
      r_sync1    <= tape_in;
      r_sync2    <= r_sync1;
      r_lvl_prev <= w_lvl;
      if (w_edge) begin
        r_cnt   <= '0;
        r_first <= 1'b0;
      end else if (r_cnt < C_TO) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_timeout) r_first <= 1'b1;
    end
  end

  // Half classification and bit assembly; an opposite half restarts the pending group
  always_comb begin
    w_half_vld  = w_edge && !r_first && (r_cnt < C_TO);
    w_half      = (r_cnt <= C_SHORT) ? HALF_S : HALF_L;
    w_bit_vld   = 1'b0;
    w_bit       = 1'b0;
    w_pend_s_nx = r_pend_s;
    w_pend_l_nx = r_pend_l;
    if (w_half_vld) begin
      if (w_half == HALF_S) begin
        if (r_pend_l) begin
          w_pend_l_nx = 1'b0;
          w_pend_s_nx = 2'd1;
        end else if (r_pend_s == 2'd3) begin
          w_bit_vld   = 1'b1;
          w_bit       = 1'b1;
          w_pend_s_nx = 2'd0;
        end else begin
          w_pend_s_nx = r_pend_s + 2'd1;
        end
      end else begin
        if (r_pend_s != 2'd0) begin
          w_pend_s_nx = 2'd0;
          w_pend_l_nx = 1'b1;
        end else if (r_pend_l) begin
          w_bit_vld   = 1'b1;
          w_bit       = 1'b0;
          w_pend_l_nx = 1'b0;
        end else begin
          w_pend_l_nx = 1'b1;
        end
      end
    end
  end

  // Frame FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_HUNT;
      r_lead    <= '0;
      r_idx     <= '0;
      r_pend_s  <= '0;
      r_pend_l  <= 1'b0;
      r_carrier <= 1'b0;
      r_dv      <= 1'b0;
      r_fe      <= 1'b0;
      r_dout    <= 8'h00;
    end else begin
      r_dv <= 1'b0;
      r_fe <= 1'b0;
      if (w_timeout) begin
        r_state   <= ST_HUNT;
        r_carrier <= 1'b0;
        r_pend_s  <= '0;
        r_pend_l  <= 1'b0;
        r_lead    <= '0;
        r_idx     <= '0;
      end else begin
        r_pend_s <= w_pend_s_nx;
        r_pend_l <= w_pend_l_nx;
        if (w_bit_vld) begin
          unique case (r_state)
            ST_HUNT: begin
              if (!w_bit) begin
                r_lead <= '0;
              end else if (r_lead == LEAD_W'(LEADER_BITS - 1)) begin
                r_lead    <= '0;
                r_carrier <= 1'b1;
                r_state   <= ST_WAIT_START;
              end else begin
                r_lead <= r_lead + 1'b1;
              end
            end
            ST_WAIT_START: begin
              if (!w_bit) begin
                r_idx   <= '0;
                r_state <= ST_DATA;
              end
            end
            ST_DATA: begin
              r_idx <= r_idx + 3'd1;
              if (r_idx == 3'd7) r_state <= ST_STOP;
            end
            ST_STOP: begin
              if (w_bit) begin
                r_dout <= r_shift;
                r_dv   <= 1'b1;
              end else begin
                r_fe <= 1'b1;
              end
              r_state <= ST_WAIT_START;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_bit_vld && (r_state == ST_DATA)) r_shift <= {w_bit, r_shift[7:1]};
  end

  assign dout       = r_dout;
  assign data_valid = r_dv;
  assign frame_err  = r_fe;
  assign carrier    = r_carrier;

endmodule

// File: tb/tb_tape_demod.sv
// Directed bench for tape_demod with scaled timing (S=100, L=200 clk per half).
module tb_tape_demod;

  localparam int SMAX = 150;
  localparam int TOUT = 300;
  localparam int LBIT = 16;
  localparam int GCLK = 64;
  localparam int HS   = 100;
  localparam int HL   = 200;
`ifdef TAPE_DEMOD_GLITCH_EN
  localparam int LAT       = 3 + GCLK;
  localparam int GLITCH_ON = 1;
`else
  localparam int LAT       = 3;
  localparam int GLITCH_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tape_in = 1'b0;
  logic [7:0] dout;
  logic       data_valid, frame_err, carrier;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_tog = 0;
  int n_valid = 0, n_ferr = 0, n_5a = 0;
  int valid_cyc = 0, rise_cyc = 0, fall_cyc = 0;
  logic [7:0] last_dout = 8'h00;
  logic carrier_q = 1'b0;

  tape_demod #(
    .SHORT_MAX   (SMAX),
    .TIMEOUT     (TOUT),
    .LEADER_BITS (LBIT),
    .GLITCH_CLKS (GCLK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tape_in    (tape_in),
    .dout       (dout),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .carrier    (carrier)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid) begin
      n_valid   = n_valid + 1;
      valid_cyc = cyc;
      last_dout = dout;
      if (dout == 8'h5A) n_5a = n_5a + 1;
    end
    if (frame_err) n_ferr = n_ferr + 1;
    if (carrier && !carrier_q) rise_cyc = cyc;
    if (!carrier && carrier_q) fall_cyc = cyc;
    carrier_q = carrier;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic half(input int n);
    tick(n);
    tape_in  = ~tape_in;
    last_tog = cyc;
  endtask

  task automatic spike_half(input int n);
    tick(n / 2 - 5);
    tape_in = ~tape_in;
    tick(10);
    tape_in = ~tape_in;
    tick(n - n / 2 - 5);
    tape_in  = ~tape_in;
    last_tog = cyc;
  endtask

  task automatic send_bit(input logic b, input logic spk);
    if (b) begin
      repeat (4) half(HS);
    end else begin
      if (spk) spike_half(HL);
      else     half(HL);
      half(HL);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic spk);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], spk);
    send_bit(stop, 1'b0);
  endtask

  task automatic leader();
    repeat (64) half(HS);
  endtask

  initial begin
    int v0, f0, a0;
    logic [7:0] b96;
    b96 = 8'h96;

    tick(3);
    reset = 1'b0;
    tick(2);
    check("rst_dout", dout, 8'h00);
    check("rst_valid", data_valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_carrier", carrier, 0);

    // leader lock
    half(20);
    leader();
    tick(LAT + 2);
    check("lead_carrier", carrier, 1);
    check("lead_latency", rise_cyc - last_tog, LAT);
    check("lead_no_valid", n_valid, 0);

    // good frame A5
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(LAT + 2);
    check("a5_pulses", n_valid - v0, 1);
    check("a5_dout", last_dout, 8'hA5);
    check("a5_latency", valid_cyc - last_tog, LAT);
    check("a5_no_ferr", n_ferr - f0, 0);

    // bad stop bit, then good frame 01
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(LAT + 2);
    check("3c_ferr", n_ferr - f0, 1);
    check("3c_no_valid", n_valid - v0, 0);
    check("3c_dout_kept", dout, 8'hA5);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    v0 = n_valid;
    send_frame(8'h01, 1'b1, 1'b0);
    tick(LAT + 2);
    check("01_pulses", n_valid - v0, 1);
    check("01_dout", dout, 8'h01);

    // S,S,L,L as data bit 0 of 8'h96
    send_bit(1'b1, 1'b0);
    v0 = n_valid;
    send_bit(1'b0, 1'b0);
    half(HS); half(HS); half(HL); half(HL);
    for (int i = 1; i < 8; i++) send_bit(b96[i], 1'b0);
    send_bit(1'b1, 1'b0);
    tick(LAT + 2);
    check("ssll_pulses", n_valid - v0, 1);
    check("ssll_dout", dout, 8'h96);

    // carrier timeout mid-byte
    v0 = n_valid; f0 = n_ferr;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    tick(TOUT + LAT + 20);
    check("to_carrier", carrier, 0);
    check("to_fall_cycle", fall_cyc - last_tog, LAT + TOUT);
    check("to_no_valid", n_valid - v0, 0);
    check("to_no_ferr", n_ferr - f0, 0);
    half(HS);
    leader();
    tick(LAT + 2);
    check("relock_carrier", carrier, 1);

    // spikes inside the long halves of 8'h5A
    a0 = n_5a;
    send_frame(8'h5A, 1'b1, 1'b1);
    repeat (4) send_bit(1'b1, 1'b0);
    tick(LAT + 2);
    check("spike_5a", n_5a - a0, GLITCH_ON);

    // reset in the middle of a byte
    v0 = n_valid; f0 = n_ferr;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    tick(7);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    repeat (8) send_bit(1'b1, 1'b0);
    tick(LAT + 2);
    check("mid_rst_no_valid", n_valid - v0, 0);
    check("mid_rst_no_ferr", n_ferr - f0, 0);
    check("mid_rst_dout", dout, 8'h00);
    check("mid_rst_carrier", carrier, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
